// File: rtl/channel_control_unit.sv
// Device-side bus-and-tag control unit: answers selection for DEVICE_ADDR, takes a command, moves bytes to/from AXI-Stream.
// Latency 3 aclk tag-to-response; service_in is withheld while an m_axis byte awaits tready, s_axis is pulled one byte at a time.
module channel_control_unit #(
    parameter logic [7:0] DEVICE_ADDR = 8'h10
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [7:0] bus_out,
    input  logic       operational_out,
    input  logic       select_out,
    input  logic       hold_out,
    input  logic       address_out,
    input  logic       command_out,
    input  logic       service_out,
    input  logic       suppress_out,
    output logic [7:0] bus_in,
    output logic       operational_in,
    output logic       select_in,
    output logic       address_in,
    output logic       status_in,
    output logic       service_in,
    output logic       request_in,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic [7:0] command,
    output logic       command_strobe
);

    typedef enum logic [3:0] {
        IDLE, SEL, ADDR, CMD, ISTAT, ISTAT_W, DATA, DATA_W, ESTAT, ESTAT_W
    } state_t;

    logic unused_suppress;
    assign unused_suppress = suppress_out;

    logic [5:0] tag_raw;
    logic [5:0] sync1_q, sync1_d, sync2_q, sync2_d;
    assign tag_raw = {operational_out, select_out, hold_out, address_out, command_out, service_out};

    logic op_s, sel_s, hold_s, addr_s, cmd_s, svc_s;
    assign {op_s, sel_s, hold_s, addr_s, cmd_s, svc_s} = sync2_q;

    state_t     state_q, state_d;
    logic       match_q, match_d;
    logic       op_in_q, op_in_d;
    logic       sel_in_q, sel_in_d;
    logic       addr_in_q, addr_in_d;
    logic       stat_in_q, stat_in_d;
    logic       serv_in_q, serv_in_d;
    logic [7:0] bus_in_q, bus_in_d;
    logic [7:0] command_q, command_d;
    logic       strobe_q, strobe_d;
    logic [7:0] m_tdata_q, m_tdata_d;
    logic       m_tvalid_q, m_tvalid_d;
    logic       s_tready_q, s_tready_d;
    logic       end_q, end_d;
    logic       tlast_q, tlast_d;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            state_q    <= IDLE;
            match_q    <= 1'b0;
            op_in_q    <= 1'b0;
            sel_in_q   <= 1'b0;
            addr_in_q  <= 1'b0;
            stat_in_q  <= 1'b0;
            serv_in_q  <= 1'b0;
            bus_in_q   <= '0;
            command_q  <= '0;
            strobe_q   <= 1'b0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            s_tready_q <= 1'b0;
            end_q      <= 1'b0;
            tlast_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            state_q    <= state_d;
            match_q    <= match_d;
            op_in_q    <= op_in_d;
            sel_in_q   <= sel_in_d;
            addr_in_q  <= addr_in_d;
            stat_in_q  <= stat_in_d;
            serv_in_q  <= serv_in_d;
            bus_in_q   <= bus_in_d;
            command_q  <= command_d;
            strobe_q   <= strobe_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            s_tready_q <= s_tready_d;
            end_q      <= end_d;
            tlast_q    <= tlast_d;
        end
    end

    always_comb begin
        sync1_d    = tag_raw;
        sync2_d    = sync1_q;
        state_d    = state_q;
        match_d    = match_q;
        op_in_d    = op_in_q;
        sel_in_d   = 1'b0;
        addr_in_d  = addr_in_q;
        stat_in_d  = stat_in_q;
        serv_in_d  = serv_in_q;
        bus_in_d   = bus_in_q;
        command_d  = command_q;
        strobe_d   = 1'b0;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q && !m_axis_tready;
        s_tready_d = 1'b0;
        end_d      = end_q;
        tlast_d    = tlast_q;

        // Selective reset clears the channel side only; a held m_axis byte survives it.
        if (!op_s) begin
            state_d   = IDLE;
            match_d   = 1'b0;
            op_in_d   = 1'b0;
            addr_in_d = 1'b0;
            stat_in_d = 1'b0;
            serv_in_d = 1'b0;
            bus_in_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (addr_s) match_d = (bus_out == DEVICE_ADDR);
                    if (sel_s && hold_s && match_q) begin
                        op_in_d = 1'b1;
                        match_d = 1'b0;
                        state_d = SEL;
                    end else begin
                        sel_in_d = sel_s;
                    end
                end
                SEL: begin
                    if (!sel_s) begin
                        op_in_d = 1'b0;
                        state_d = IDLE;
                    end else if (!addr_s) begin
                        bus_in_d  = DEVICE_ADDR;
                        addr_in_d = 1'b1;
                        state_d   = ADDR;
                    end
                end
                ADDR: begin
                    if (cmd_s) begin
                        command_d = bus_out;
                        strobe_d  = 1'b1;
                        addr_in_d = 1'b0;
                        bus_in_d  = '0;
                        state_d   = CMD;
                    end
                end
                CMD: begin
                    if (!cmd_s) begin
                        bus_in_d  = (command_q == 8'h00) ? 8'h0C : 8'h00;
                        stat_in_d = 1'b1;
                        state_d   = ISTAT;
                    end
                end
                ISTAT: begin
                    if (svc_s || cmd_s) begin
                        stat_in_d = 1'b0;
                        state_d   = ISTAT_W;
                    end
                end
                ISTAT_W: begin
                    if (!svc_s && !cmd_s) begin
                        bus_in_d = '0;
                        if (command_q == 8'h00) begin
                            op_in_d = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    // A channel stop takes priority over a concurrent service_out.
                    if (cmd_s) begin
                        serv_in_d = 1'b0;
                        end_d     = 1'b1;
                        state_d   = DATA_W;
                    end else if (serv_in_q && svc_s) begin
                        serv_in_d = 1'b0;
                        state_d   = DATA_W;
                        if (command_q[0]) begin
                            m_tdata_d  = bus_out;
                            m_tvalid_d = 1'b1;
                            end_d      = 1'b0;
                        end else begin
                            end_d = tlast_q;
                        end
                    end else if (!serv_in_q) begin
                        if (command_q[0]) begin
                            serv_in_d = !m_tvalid_q;
                        end else if (s_axis_tvalid) begin
                            s_tready_d = 1'b1;
                            bus_in_d   = s_axis_tdata;
                            tlast_d    = s_axis_tlast;
                            serv_in_d  = 1'b1;
                        end
                    end
                end
                DATA_W: begin
                    if (!svc_s && !cmd_s) begin
                        if (end_q) begin
                            bus_in_d  = 8'h0C;
                            stat_in_d = 1'b1;
                            state_d   = ESTAT;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
                ESTAT: begin
                    if (svc_s || cmd_s) begin
                        stat_in_d = 1'b0;
                        state_d   = ESTAT_W;
                    end
                end
                ESTAT_W: begin
                    if (!svc_s && !cmd_s) begin
                        op_in_d  = 1'b0;
                        bus_in_d = '0;
                        end_d    = 1'b0;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus_in         = bus_in_q;
    assign operational_in = op_in_q;
    assign select_in      = sel_in_q;
    assign address_in     = addr_in_q;
    assign status_in      = stat_in_q;
    assign service_in     = serv_in_q;
    assign request_in     = 1'b0;
    assign m_axis_tdata   = m_tdata_q;
    assign m_axis_tvalid  = m_tvalid_q;
    assign s_axis_tready  = s_tready_q;
    assign command        = command_q;
    assign command_strobe = strobe_q;

endmodule

// File: tb/tb_channel_control_unit.sv
// Channel-side driver for channel_control_unit with a byte scoreboard for bus_in and m_axis results.
module tb_channel_control_unit;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [7:0] bus_out = '0;
    logic       operational_out = 1'b0, select_out = 1'b0, hold_out = 1'b0, address_out = 1'b0;
    logic       command_out = 1'b0, service_out = 1'b0, suppress_out = 1'b0;
    logic [7:0] bus_in;
    logic       operational_in, select_in, address_in, status_in, service_in, request_in;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
    logic [7:0] s_axis_tdata = '0;
    logic       s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
    logic       s_axis_tready;
    logic [7:0] command;
    logic       command_strobe;

    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;
    logic [7:0] exp_q[$];

    channel_control_unit #(.DEVICE_ADDR(8'h10)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus_out(bus_out),
        .operational_out(operational_out), .select_out(select_out), .hold_out(hold_out),
        .address_out(address_out), .command_out(command_out), .service_out(service_out),
        .suppress_out(suppress_out), .bus_in(bus_in), .operational_in(operational_in),
        .select_in(select_in), .address_in(address_in), .status_in(status_in),
        .service_in(service_in), .request_in(request_in),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .command(command), .command_strobe(command_strobe)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) if (command_strobe === 1'b1) strobe_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    function automatic logic sig_val(input int idx);
        case (idx)
            0: return operational_in;
            1: return select_in;
            2: return address_in;
            3: return status_in;
            4: return service_in;
            5: return m_axis_tvalid;
            default: return s_axis_tready;
        endcase
    endfunction

    task automatic wait_sig(input int idx, input logic val, input string name);
        int n = 0;
        while (sig_val(idx) !== val && n < 60) begin
            tick(1);
            n++;
        end
        tests++;
        if (sig_val(idx) !== val) begin
            fails++;
            $display("FAIL wait_%s: got %b want %b after %0d cycles", name, sig_val(idx), val, n);
        end
    endtask

    task automatic do_select();
        logic [7:0] e;
        bus_out = 8'h10;
        address_out = 1'b1;
        tick(4);
        select_out = 1'b1;
        hold_out = 1'b1;
        wait_sig(0, 1'b1, "op_in_up");
        address_out = 1'b0;
        bus_out = 8'h00;
        exp_q.push_back(8'h10);
        wait_sig(2, 1'b1, "address_in_up");
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        tests++;
        if (bus_in !== e) begin fails++; $display("FAIL addr_bus: got %h want %h", bus_in, e); end
    endtask

    task automatic do_command(input logic [7:0] cmd, input logic [7:0] istat);
        logic [7:0] e;
        bus_out = cmd;
        command_out = 1'b1;
        wait_sig(2, 1'b0, "address_in_down");
        tests++;
        if (command !== cmd) begin fails++; $display("FAIL command: got %h want %h", command, cmd); end
        command_out = 1'b0;
        bus_out = 8'h00;
        exp_q.push_back(istat);
        wait_sig(3, 1'b1, "istat_up");
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        tests++;
        if (bus_in !== e) begin fails++; $display("FAIL init_status: got %h want %h", bus_in, e); end
        service_out = 1'b1;
        wait_sig(3, 1'b0, "istat_down");
        service_out = 1'b0;
    endtask

    task automatic end_status();
        logic [7:0] e;
        exp_q.push_back(8'h0C);
        wait_sig(3, 1'b1, "estat_up");
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        tests++;
        if (bus_in !== e) begin fails++; $display("FAIL end_status: got %h want %h", bus_in, e); end
        service_out = 1'b1;
        wait_sig(3, 1'b0, "estat_down");
        service_out = 1'b0;
        wait_sig(0, 1'b0, "op_in_down");
        tests++;
        if (bus_in !== 8'h00) begin fails++; $display("FAIL end_bus_idle: got %h want 00", bus_in); end
        select_out = 1'b0;
        hold_out = 1'b0;
        tick(4);
    endtask

    task automatic send_write_byte(input logic [7:0] b);
        wait_sig(4, 1'b1, "wr_service_up");
        bus_out = b;
        exp_q.push_back(b);
        service_out = 1'b1;
        wait_sig(4, 1'b0, "wr_service_down");
        service_out = 1'b0;
        bus_out = 8'h00;
        wait_sig(5, 1'b1, "m_tvalid_up");
    endtask

    task automatic accept_m_byte(input string name);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        tests++;
        if (m_axis_tdata !== e) begin fails++; $display("FAIL %s: got %h want %h", name, m_axis_tdata, e); end
        m_axis_tready = 1'b1;
        tick(1);
        m_axis_tready = 1'b0;
        tests++;
        if (m_axis_tvalid !== 1'b0) begin fails++; $display("FAIL %s_tvalid_clear: got %b want 0", name, m_axis_tvalid); end
    endtask

    task automatic channel_stop();
        wait_sig(4, 1'b1, "stop_service_up");
        command_out = 1'b1;
        wait_sig(4, 1'b0, "stop_service_down");
        command_out = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        tick(3);
        tests++;
        if ({operational_in, select_in, address_in, status_in, service_in, request_in} !== 6'b0) begin
            fails++;
            $display("FAIL reset_tags: got %b want 000000",
                     {operational_in, select_in, address_in, status_in, service_in, request_in});
        end
        tests++;
        if ({bus_in, m_axis_tdata, command} !== 24'h0) begin
            fails++; $display("FAIL reset_data: got %h want 000000", {bus_in, m_axis_tdata, command});
        end
        tests++;
        if ({m_axis_tvalid, s_axis_tready, command_strobe} !== 3'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 000", {m_axis_tvalid, s_axis_tready, command_strobe});
        end
        aresetn = 1'b1;
        operational_out = 1'b1;
        tick(4);
    endtask

    task automatic test_no_match();
        bus_out = 8'h22;
        address_out = 1'b1;
        tick(4);
        select_out = 1'b1;
        hold_out = 1'b1;
        tick(2);
        tests++;
        if (select_in !== 1'b0) begin fails++; $display("FAIL prop_early: got %b want 0", select_in); end
        tick(1);
        tests++;
        if (select_in !== 1'b1) begin fails++; $display("FAIL prop_3clk: got %b want 1", select_in); end
        tick(4);
        tests++;
        if (operational_in !== 1'b0) begin fails++; $display("FAIL nomatch_op: got %b want 0", operational_in); end
        select_out = 1'b0;
        hold_out = 1'b0;
        address_out = 1'b0;
        bus_out = 8'h00;
        tick(4);
        tests++;
        if (select_in !== 1'b0) begin fails++; $display("FAIL prop_drop: got %b want 0", select_in); end
    endtask

    task automatic test_test_io();
        int s0 = strobe_cnt;
        do_select();
        do_command(8'h00, 8'h0C);
        wait_sig(0, 1'b0, "tio_op_down");
        tests++;
        if (bus_in !== 8'h00) begin fails++; $display("FAIL tio_bus: got %h want 00", bus_in); end
        tick(2);
        tests++;
        if (strobe_cnt !== s0 + 1) begin fails++; $display("FAIL strobe_count: got %0d want %0d", strobe_cnt - s0, 1); end
        select_out = 1'b0;
        hold_out = 1'b0;
        tick(4);
    endtask

    task automatic test_write();
        do_select();
        do_command(8'h01, 8'h00);
        send_write_byte(8'hA5);
        accept_m_byte("wr_byte0");
        send_write_byte(8'h5A);
        accept_m_byte("wr_byte1");
        channel_stop();
        end_status();
    endtask

    task automatic test_write_stall();
        do_select();
        do_command(8'h01, 8'h00);
        send_write_byte(8'h3C);
        tick(12);
        tests++;
        if ({service_in, m_axis_tvalid} !== 2'b01) begin
            fails++; $display("FAIL stall_hold: got svc=%b tvalid=%b want svc=0 tvalid=1", service_in, m_axis_tvalid);
        end
        accept_m_byte("stall_byte");
        wait_sig(4, 1'b1, "stall_resume");
        channel_stop();
        end_status();
    endtask

    task automatic test_read();
        logic [7:0] b, e;
        do_select();
        do_command(8'h02, 8'h00);
        for (int i = 0; i < 2; i++) begin
            b = (i == 0) ? 8'h11 : 8'h22;
            s_axis_tdata = b;
            s_axis_tlast = (i == 1);
            s_axis_tvalid = 1'b1;
            exp_q.push_back(b);
            wait_sig(6, 1'b1, "s_tready_up");
            tick(1);
            s_axis_tvalid = 1'b0;
            s_axis_tlast = 1'b0;
            tests++;
            if (s_axis_tready !== 1'b0) begin fails++; $display("FAIL s_tready_pulse: got %b want 0", s_axis_tready); end
            wait_sig(4, 1'b1, "rd_service_up");
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            tests++;
            if (bus_in !== e) begin fails++; $display("FAIL rd_byte%0d: got %h want %h", i, bus_in, e); end
            service_out = 1'b1;
            wait_sig(4, 1'b0, "rd_service_down");
            service_out = 1'b0;
        end
        end_status();
    endtask

    task automatic test_sel_reset();
        do_select();
        do_command(8'h01, 8'h00);
        send_write_byte(8'h77);
        operational_out = 1'b0;
        tick(3);
        tests++;
        if ({operational_in, select_in, address_in, status_in, service_in} !== 5'b0 || bus_in !== 8'h00) begin
            fails++;
            $display("FAIL selreset_tags: got tags=%b bus=%h want 00000 00",
                     {operational_in, select_in, address_in, status_in, service_in}, bus_in);
        end
        tests++;
        if (m_axis_tvalid !== 1'b1) begin fails++; $display("FAIL selreset_pending: got %b want 1", m_axis_tvalid); end
        accept_m_byte("selreset_byte");
        operational_out = 1'b1;
        select_out = 1'b0;
        hold_out = 1'b0;
        tick(4);
        do_select();
        do_command(8'h00, 8'h0C);
        wait_sig(0, 1'b0, "resel_op_down");
        select_out = 1'b0;
        hold_out = 1'b0;
        tick(4);
    endtask

    task automatic test_reset_mid();
        do_select();
        do_command(8'h01, 8'h00);
        send_write_byte(8'hEE);
        void'(exp_q.pop_front());
        aresetn = 1'b0;
        tick(1);
        tests++;
        if ({m_axis_tvalid, operational_in} !== 2'b00 || command !== 8'h00 || bus_in !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid: got tvalid=%b op=%b cmd=%h bus=%h want 0 0 00 00",
                     m_axis_tvalid, operational_in, command, bus_in);
        end
        aresetn = 1'b1;
        select_out = 1'b0;
        hold_out = 1'b0;
        tick(4);
    endtask

    initial begin
        test_reset();
        test_no_match();
        test_test_io();
        test_write();
        test_write_stall();
        test_read();
        test_sel_reset();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
